mcp_mib_host: RTL and testbench
===============================

// Module: mcp_mib_host
// PURPOSE
//  Control-chip end of the MCP-1631 microinstruction bus (MIB). Generates the
//  four non-overlapping phases C1..C4 from one clock and drives the next
//  microaddress, active-low, during C2. Optionally pulls line 16 low in C3 to
//  deselect the ROM. Samples the microinstruction the ROM discharges during C1
//  and hands it to the microsequencer. The open-drain bus is split: m_in
//  (sensed level) and m_pull (1 = pull line low).
// PARAMETERS
//  PHASE_LEN  2   clocks per phase, >=1; one bus cycle = 4*PHASE_LEN clocks
// PORTS
//  pin_clk     in   1   system clock, all logic on rising edge
//  pin_rst_n   in   1   asynchronous active-low reset
//  run         in   1   1 = cycle the bus, 0 = halt at next C1 end
//  upc_addr    in   11  next microaddress, true polarity
//  upc_valid   in   1   upc_addr valid
//  upc_ready   out  1   address taken this clock when upc_valid=1
//  mi_inhibit  in   1   sampled with address: deselect ROM for that slot
//  mi_data     out  22  microinstruction, true polarity (= ~m_in at sample)
//  mi_valid    out  1   one-clock strobe, mi_data updated
//  pin_c1..c4  out  1   phase outputs, at most one high
//  m_in        in   22  sensed MIB line levels
//  m_pull      out  22  open-drain pull-low enables
//  addr_err    out  1   sticky address echo mismatch (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: FSM=IDLE, phase counter 0, slot flags clear, all outputs 0.
//    Reset mid-cycle aborts the cycle immediately and releases every m_pull line.
//  - FSM: IDLE -> C4 when run=1; C4 -> C1 -> C2 -> C3 -> C4 -> ...
//    Each phase lasts PHASE_LEN clocks. pin_cN is high for the whole phase.
//    Phases change on the clock after the counter reaches PHASE_LEN-1.
//  - Halt: at the last clock of C1 with run=0, go to IDLE. No address is taken.
//    Pending data is still delivered at that C1.
//  - upc_ready=1 only on the last clock of C1 when run=1. If upc_valid is also 1,
//    latch upc_addr into addr_q and mi_inhibit into inh_q, and set slot_q=1.
//    If upc_valid=0, the slot is empty: slot_q=0 and inh_q is forced to 1.
//  - C2: m_pull[10:0]=addr_q. Pulling a line low encodes a 1. All other lines released.
//  - C3: m_pull[16]=inh_q. All other lines released.
//  - C4, C1, IDLE: m_pull=0. Precharge belongs to the ROM.
//  - On the last clock of C1: mi_data <= ~m_in and pend_q <= slot_q from the prior C2.
//    mi_valid pulses for one clock on the next clock, only if the slot was pending.
//    Empty slots produce no strobe. mi_data holds its value between strobes.
//  - Inhibited valid slot: the ROM stays quiet and the bus reads precharged high.
//    mi_valid still pulses with mi_data=0 (NOP).
//  - Latency: address accepted -> mi_valid is 4*PHASE_LEN+1 clocks.
//    Throughput is one word per bus cycle.
//  - The first C1 after leaving IDLE has no pending slot and gives no strobe.
//  - run is sampled only on the last clock of C1. Changes elsewhere are ignored.
// CONFIGURATION
//  MCP_MIB_ECHO_CHECK_EN defined: on the last clock of C2, compare ~m_in[10:0]
//  with addr_q for a valid slot. On a mismatch (bus contention or a stuck line),
//  set addr_err. addr_err stays set until reset.
//  Macro undefined: no comparator is built and addr_err is tied to 0.
// TESTING (PHASE_LEN=2, ROM model on bus, pull-ups)
//  1. Reset release, run=1: C4,C1,C2,C3 each 2 clocks, one-hot. No mi_valid in the
//     first C1. m_pull=0 everywhere except C2 and C3.
//  2. upc_addr=11'h123 valid, ROM[0x123]=22'h2A5A5A -> m_pull[10:0]=11'h123 in C2.
//     mi_valid 9 clocks after acceptance, mi_data=22'h2A5A5A.
//  3. upc_addr=11'h7FF with mi_inhibit=1 -> m_pull[16]=1 in C3, m_pull[15:0]=0
//     in C3. The strobe gives mi_data=0.
//  4. upc_valid=0 for one slot between valid 11'h001 and 11'h002 -> exactly two
//     strobes, spaced 16 clocks apart.
//  5. run=0 during C3 -> the pending word is strobed, then IDLE with all outputs
//     low. run=1 -> restart at C4.
//  6. pin_rst_n low mid-C2 -> m_pull=0 and pin_c*=0 asynchronously.
//     ECHO_EN build: force m_in[3]=1 during C2 with addr bit3=1 -> addr_err=1.

Source files
------------

// File: rtl/mcp_mib_host.sv
// rtl/mcp_mib_host.sv - MCP-1631 microinstruction bus host: C1..C4 phase generator, address drive, word capture.
// Optional build macro MCP_MIB_ECHO_CHECK_EN adds a sticky address-echo comparator on addr_err.
module mcp_mib_host #(
  parameter int PHASE_LEN = 2
) (
  input  logic        pin_clk,
  input  logic        pin_rst_n,
  input  logic        run,
  input  logic [10:0] upc_addr,
  input  logic        upc_valid,
  output logic        upc_ready,
  input  logic        mi_inhibit,
  output logic [21:0] mi_data,
  output logic        mi_valid,
  output logic        pin_c1,
  output logic        pin_c2,
  output logic        pin_c3,
  output logic        pin_c4,
  input  logic [21:0] m_in,
  output logic [21:0] m_pull,
  output logic        addr_err
);

  localparam int CW = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;

  typedef enum logic [2:0] {S_IDLE, S_C4, S_C1, S_C2, S_C3} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [10:0]   addr_q, addr_d;
  logic          inh_q, inh_d;
  logic          slot_q, slot_d;
  logic [21:0]   mi_data_q, mi_data_d;
  logic          mi_valid_q, mi_valid_d;
  logic [3:0]    phase_q, phase_d;
  logic [21:0]   pull_q, pull_d;
  logic          err_q, err_d;
  logic          last;

  assign last      = (cnt_q == CW'(PHASE_LEN - 1));
  assign upc_ready = (state_q == S_C1) && last && run;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    inh_d      = inh_q;
    slot_d     = slot_q;
    mi_data_d  = mi_data_q;
    mi_valid_d = 1'b0;
    err_d      = err_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (run) state_d = S_C4;
      end
      default: begin
        if (!last) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = '0;
          unique case (state_q)
            S_C4: state_d = S_C1;
            S_C1: begin
              // The word for the slot addressed one bus cycle ago is on the bus now.
              mi_data_d  = ~m_in;
              mi_valid_d = slot_q;
              if (run) begin
                state_d = S_C2;
                slot_d  = upc_valid;
                addr_d  = upc_valid ? upc_addr : 11'h000;
                inh_d   = upc_valid ? mi_inhibit : 1'b1;
              end else begin
                state_d = S_IDLE;
                slot_d  = 1'b0;
                addr_d  = 11'h000;
                inh_d   = 1'b1;
              end
            end
            S_C2: begin
              state_d = S_C3;
`ifdef MCP_MIB_ECHO_CHECK_EN
              if (slot_q && (~m_in[10:0] != addr_q)) err_d = 1'b1;
`endif
            end
            default: state_d = S_C4;
          endcase
        end
      end
    endcase

    phase_d = 4'b0000;
    pull_d  = 22'h000000;
    unique case (state_d)
      S_C1:    phase_d = 4'b0001;
      S_C2: begin
        phase_d = 4'b0010;
        pull_d  = {11'h000, addr_d};
      end
      S_C3: begin
        phase_d = 4'b0100;
        pull_d  = {5'b00000, inh_d, 16'h0000};
      end
      S_C4:    phase_d = 4'b1000;
      default: phase_d = 4'b0000;
    endcase
  end

  always_ff @(posedge pin_clk or negedge pin_rst_n) begin
    if (!pin_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= 11'h000;
      inh_q      <= 1'b0;
      slot_q     <= 1'b0;
      mi_data_q  <= 22'h000000;
      mi_valid_q <= 1'b0;
      phase_q    <= 4'b0000;
      pull_q     <= 22'h000000;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      inh_q      <= inh_d;
      slot_q     <= slot_d;
      mi_data_q  <= mi_data_d;
      mi_valid_q <= mi_valid_d;
      phase_q    <= phase_d;
      pull_q     <= pull_d;
      err_q      <= err_d;
    end
  end

  assign mi_data  = mi_data_q;
  assign mi_valid = mi_valid_q;
  assign pin_c1   = phase_q[0];
  assign pin_c2   = phase_q[1];
  assign pin_c3   = phase_q[2];
  assign pin_c4   = phase_q[3];
  assign m_pull   = pull_q;
`ifdef MCP_MIB_ECHO_CHECK_EN
  assign addr_err = err_q;
`else
  assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_mcp_mib_host.sv
// tb/tb_mcp_mib_host.sv - scoreboard bench for mcp_mib_host with a ROM model on a pulled-up bus.
module tb_mcp_mib_host;
  logic        pin_clk = 1'b0;
  logic        pin_rst_n = 1'b0;
  logic        run = 1'b1;
  logic [10:0] upc_addr = 11'h000;
  logic        upc_valid = 1'b0;
  logic        upc_ready;
  logic        mi_inhibit = 1'b0;
  logic [21:0] mi_data;
  logic        mi_valid;
  logic        pin_c1, pin_c2, pin_c3, pin_c4;
  logic [21:0] m_in;
  logic [21:0] m_pull;
  logic        addr_err;

  logic [10:0] rom_addr = 11'h000;
  logic        rom_sel = 1'b0;
  logic        force3 = 1'b0;
  logic [21:0] rom_pull;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    logic [21:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  localparam logic [3:0] PH_C1 = 4'b0001;
  localparam logic [3:0] PH_C2 = 4'b0010;
  localparam logic [3:0] PH_C3 = 4'b0100;
  localparam logic [3:0] PH_C4 = 4'b1000;

  mcp_mib_host #(.PHASE_LEN(2)) dut (
    .pin_clk(pin_clk), .pin_rst_n(pin_rst_n), .run(run),
    .upc_addr(upc_addr), .upc_valid(upc_valid), .upc_ready(upc_ready),
    .mi_inhibit(mi_inhibit), .mi_data(mi_data), .mi_valid(mi_valid),
    .pin_c1(pin_c1), .pin_c2(pin_c2), .pin_c3(pin_c3), .pin_c4(pin_c4),
    .m_in(m_in), .m_pull(m_pull), .addr_err(addr_err)
  );

  always #5 pin_clk = ~pin_clk;
  always @(posedge pin_clk) cyc++;

  function automatic logic [21:0] rom_word(input logic [10:0] a);
    if (a == 11'h123) return 22'h2A5A5A;
    return {a, a};
  endfunction

  // ROM: latches the address in C2, deselects if line 16 is low in C3, discharges in C1.
  assign rom_pull = (pin_c1 && rom_sel) ? rom_word(rom_addr) : 22'h000000;
  assign m_in = ~(m_pull | rom_pull) | (force3 ? 22'h000008 : 22'h000000);

  always @(posedge pin_clk) begin
    if (pin_c2) begin
      rom_addr <= ~m_in[10:0];
      rom_sel  <= 1'b1;
    end
    if (pin_c3 && !m_in[16]) rom_sel <= 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] phases();
    return {pin_c4, pin_c3, pin_c2, pin_c1};
  endfunction

  // Monitor: pops the scoreboard on every strobe and checks bus rules each clock.
  always @(negedge pin_clk) begin
    if (pin_rst_n) begin
      if (mi_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("strobe_data", {10'd0, mi_data}, {10'd0, e.data});
          chk("strobe_cycle", cyc, e.cyc);
        end
      end
      if ($countones(phases()) > 1) chk("phase_onehot", {28'd0, phases()}, 32'd0);
      if (!pin_c2 && !pin_c3 && m_pull != 22'h0) chk("pull_outside_c2c3", {10'd0, m_pull}, 32'd0);
    end
  end

  task automatic wait_ready(output int k);
    int n = 0;
    while (!upc_ready && n < 64) begin
      @(negedge pin_clk);
      n++;
    end
    if (!upc_ready) chk("ready_timeout", 32'd0, 32'd1);
    k = cyc;
  endtask

  task automatic offer(input logic [10:0] a, input logic inh, input logic v,
                       input logic push, input logic [21:0] exp_data, output int k);
    upc_addr   = a;
    mi_inhibit = inh;
    upc_valid  = v;
    wait_ready(k);
    if (v && push) sb.push_back('{data: exp_data, cyc: k + 9});
    @(posedge pin_clk);
    #1;
    upc_valid  = 1'b0;
    mi_inhibit = 1'b0;
  endtask

  task automatic wait_phase(input logic [3:0] ph);
    int n = 0;
    while (phases() != ph && n < 64) begin
      @(negedge pin_clk);
      n++;
    end
    if (phases() != ph) chk("phase_timeout", {28'd0, phases()}, {28'd0, ph});
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 64) begin
      @(negedge pin_clk);
      n++;
    end
    chk("drain", sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] exp_ph [10];
    int k1, k2, k3;
    logic exp_err;
    exp_ph = '{PH_C4, PH_C4, PH_C1, PH_C1, PH_C2, PH_C2, PH_C3, PH_C3, PH_C4, PH_C4};
`ifdef MCP_MIB_ECHO_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif

    repeat (3) @(negedge pin_clk);
    chk("rst_phases", {28'd0, phases()}, 32'd0);
    chk("rst_pull", {10'd0, m_pull}, 32'd0);
    chk("rst_mi_valid", {31'd0, mi_valid}, 32'd0);
    chk("rst_mi_data", {10'd0, mi_data}, 32'd0);
    chk("rst_ready", {31'd0, upc_ready}, 32'd0);
    chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
    pin_rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge pin_clk);
      chk($sformatf("phase_seq_%0d", i), {28'd0, phases()}, {28'd0, exp_ph[i]});
    end

    offer(11'h123, 1'b0, 1'b1, 1'b1, 22'h2A5A5A, k1);
    chk("c2_pull_123", {10'd0, m_pull}, 32'h000123);

    offer(11'h7FF, 1'b1, 1'b1, 1'b1, 22'h000000, k1);
    chk("c2_pull_7ff", {10'd0, m_pull}, 32'h0007FF);
    wait_phase(PH_C3);
    chk("c3_pull_inhibit", {10'd0, m_pull}, 32'h010000);

    offer(11'h001, 1'b0, 1'b1, 1'b1, 22'h000801, k1);
    offer(11'h000, 1'b0, 1'b0, 1'b0, 22'h000000, k2);
    chk("c2_pull_empty", {10'd0, m_pull}, 32'h000000);
    offer(11'h002, 1'b0, 1'b1, 1'b1, 22'h001002, k3);
    chk("slot_spacing", k3 - k1, 32'd16);
    drain();

    offer(11'h008, 1'b0, 1'b1, 1'b1, 22'h000000, k1);
    force3 = 1'b1;
    wait_phase(PH_C3);
    force3 = 1'b0;
    drain();
    chk("addr_err", {31'd0, addr_err}, {31'd0, exp_err});

    offer(11'h055, 1'b0, 1'b1, 1'b1, 22'h02A855, k1);
    wait_phase(PH_C3);
    run = 1'b0;
    drain();
    for (int i = 0; i < 4; i++) begin
      @(negedge pin_clk);
      chk("idle_phases", {28'd0, phases()}, 32'd0);
      chk("idle_pull", {10'd0, m_pull}, 32'd0);
      chk("idle_ready", {31'd0, upc_ready}, 32'd0);
    end
    run = 1'b1;
    @(negedge pin_clk);
    chk("restart_c4", {28'd0, phases()}, {28'd0, PH_C4});

    offer(11'h3C3, 1'b0, 1'b1, 1'b0, 22'h000000, k1);
    chk("pre_rst_c2", {31'd0, pin_c2}, 32'd1);
    pin_rst_n = 1'b0;
    #1;
    chk("async_rst_pull", {10'd0, m_pull}, 32'd0);
    chk("async_rst_phases", {28'd0, phases()}, 32'd0);
    @(negedge pin_clk);
    pin_rst_n = 1'b1;
    repeat (24) @(negedge pin_clk);
    chk("post_rst_queue", sb.size(), 32'd0);
    chk("post_rst_addr_err", {31'd0, addr_err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
